// File: rtl/fdiv_round_pack.sv
// Final divide stage: classifies operands, forms the result exponent, rounds to
// nearest-even and packs an IEEE-754 quotient through a two-stage valid/ready pipe.
module fdiv_round_pack #(
    parameter int WIDTH  = 23,
    parameter int EWIDTH = 8,
    parameter int BIAS   = 127
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH+EWIDTH:0]     a_bits,
    input  logic [WIDTH+EWIDTH:0]     b_bits,
    input  logic [WIDTH+2:0]          q_frac,
    input  logic                      q_dec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH+EWIDTH:0]     result,
    output logic [4:0]                flags
);

    localparam int N  = WIDTH + EWIDTH + 1;
    localparam int XW = EWIDTH + 2;

    localparam logic [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic [XW-1:0] EMAX_X = XW'((1 << EWIDTH) - 1);

    localparam logic [4:0] FL_NONE  = 5'b00000;
    localparam logic [4:0] FL_INV   = 5'b10000;
    localparam logic [4:0] FL_DZ    = 5'b01000;
    localparam logic [4:0] FL_OVF_X = 5'b00101;
    localparam logic [4:0] FL_UNF_X = 5'b00011;
    localparam logic [4:0] FL_INX   = 5'b00001;

    localparam logic [N-1:0] QNAN = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(WIDTH-1){1'b0}}};

    // Operand classification helpers; subnormals collapse into the zero class.
    function automatic logic is_zero(input logic [N-1:0] x);
        return x[N-2:WIDTH] == {EWIDTH{1'b0}};
    endfunction

    function automatic logic is_inf(input logic [N-1:0] x);
        return (x[N-2:WIDTH] == {EWIDTH{1'b1}}) && (x[WIDTH-1:0] == {WIDTH{1'b0}});
    endfunction

    function automatic logic is_nan(input logic [N-1:0] x);
        return (x[N-2:WIDTH] == {EWIDTH{1'b1}}) && (x[WIDTH-1:0] != {WIDTH{1'b0}});
    endfunction

    function automatic logic [N-1:0] signed_inf(input logic s);
        return {s, {EWIDTH{1'b1}}, {WIDTH{1'b0}}};
    endfunction

    function automatic logic [N-1:0] signed_zero(input logic s);
        return {s, {(N-1){1'b0}}};
    endfunction

    // Pipeline state
    logic              s1_valid_r;
    logic              s1_sign_r;
    logic              s1_special_r;
    logic [N-1:0]      s1_spec_res_r;
    logic [4:0]        s1_spec_flags_r;
    logic [XW-1:0]     s1_exp_r;
    logic [WIDTH-1:0]  s1_frac_r;
    logic              s1_rnd_r;
    logic              s1_inexact_r;
    logic              out_valid_r;
    logic [N-1:0]      result_r;
    logic [4:0]        flags_r;

    logic              s2_free_s;
    logic              in_ready_s;
    logic              load1_s;

    assign s2_free_s  = !out_valid_r || out_ready;
    assign in_ready_s = !s1_valid_r || s2_free_s;
    assign load1_s    = in_valid && in_ready_s;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;

    // Stage 1 combinational: specials, exponent and round decision
    logic              sign_s;
    logic              za_s, zb_s, ia_s, ib_s, na_s, nb_s;
    logic              special_s;
    logic [N-1:0]      spec_res_s;
    logic [4:0]        spec_flags_s;
    logic [XW-1:0]     exp_s;
    logic              g_s, r_s, st_s;
    logic              rnd_s;

    assign sign_s = a_bits[N-1] ^ b_bits[N-1];
    assign za_s   = is_zero(a_bits);
    assign zb_s   = is_zero(b_bits);
    assign ia_s   = is_inf(a_bits);
    assign ib_s   = is_inf(b_bits);
    assign na_s   = is_nan(a_bits);
    assign nb_s   = is_nan(b_bits);

    assign g_s   = q_frac[2];
    assign r_s   = q_frac[1];
    assign st_s  = q_frac[0];
    assign rnd_s = g_s && (r_s || st_s || q_frac[3]);

    assign exp_s = {2'b00, a_bits[N-2:WIDTH]} - {2'b00, b_bits[N-2:WIDTH]}
                 + BIAS_X - {{(XW-1){1'b0}}, q_dec};

    // Special-operand priority: NaN/invalid, then infinity, then zero
    always_comb begin
        special_s    = 1'b0;
        spec_res_s   = {N{1'b0}};
        spec_flags_s = FL_NONE;
        if (na_s || nb_s || (ia_s && ib_s) || (za_s && zb_s)) begin
            special_s    = 1'b1;
            spec_res_s   = QNAN;
            spec_flags_s = FL_INV;
        end else if (ia_s || zb_s) begin
            special_s    = 1'b1;
            spec_res_s   = signed_inf(sign_s);
            spec_flags_s = (zb_s && !ia_s && !za_s) ? FL_DZ : FL_NONE;
        end else if (za_s || ib_s) begin
            special_s    = 1'b1;
            spec_res_s   = signed_zero(sign_s);
            spec_flags_s = FL_NONE;
        end else begin
            special_s    = 1'b0;
            spec_res_s   = {N{1'b0}};
            spec_flags_s = FL_NONE;
        end
    end

    // Stage 1 register: loads on every input transfer, empties when stage 2 takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r      <= 1'b0;
            s1_sign_r       <= 1'b0;
            s1_special_r    <= 1'b0;
            s1_spec_res_r   <= {N{1'b0}};
            s1_spec_flags_r <= FL_NONE;
            s1_exp_r        <= {XW{1'b0}};
            s1_frac_r       <= {WIDTH{1'b0}};
            s1_rnd_r        <= 1'b0;
            s1_inexact_r    <= 1'b0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= in_valid;
            end
            if (load1_s) begin
                s1_sign_r       <= sign_s;
                s1_special_r    <= special_s;
                s1_spec_res_r   <= spec_res_s;
                s1_spec_flags_r <= spec_flags_s;
                s1_exp_r        <= exp_s;
                s1_frac_r       <= q_frac[WIDTH+2:3];
                s1_rnd_r        <= rnd_s;
                s1_inexact_r    <= g_s | r_s | st_s;
            end
        end
    end

    // Stage 2 combinational: apply rounding, range check, pack
    logic [WIDTH:0]    sum_s;
    logic [XW-1:0]     exp2_s;
    logic              ovf_s;
    logic              unf_s;
    logic [N-1:0]      res2_s;
    logic [4:0]        flags2_s;

    assign sum_s  = {1'b0, s1_frac_r} + {{WIDTH{1'b0}}, s1_rnd_r};
    assign exp2_s = s1_exp_r + {{(XW-1){1'b0}}, sum_s[WIDTH]};
    assign ovf_s  = $signed(exp2_s) >= $signed(EMAX_X);
    assign unf_s  = exp2_s[XW-1] || (exp2_s == {XW{1'b0}});

    // Result select; specials bypass rounding and range handling
    always_comb begin
        res2_s   = {N{1'b0}};
        flags2_s = FL_NONE;
        if (s1_special_r) begin
            res2_s   = s1_spec_res_r;
            flags2_s = s1_spec_flags_r;
        end else if (ovf_s) begin
            res2_s   = signed_inf(s1_sign_r);
            flags2_s = FL_OVF_X;
        end else if (unf_s) begin
            res2_s   = signed_zero(s1_sign_r);
            flags2_s = FL_UNF_X;
        end else begin
            res2_s   = {s1_sign_r, exp2_s[EWIDTH-1:0], sum_s[WIDTH-1:0]};
            flags2_s = s1_inexact_r ? FL_INX : FL_NONE;
        end
    end

    // Stage 2 register: holds result steady while the consumer stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            result_r    <= {N{1'b0}};
            flags_r     <= FL_NONE;
        end else if (s2_free_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= res2_s;
                flags_r  <= flags2_s;
            end else begin
                result_r <= result_r;
                flags_r  <= flags_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
            result_r    <= result_r;
            flags_r     <= flags_r;
        end
    end

endmodule
